spi_slave_bmm150_regs: RTL and testbench

//  SPI responder that emulates the BMM150 register interface on the FPGA side of the SPI bus.

---
 rtl/spi_slave_bmm150_regs.sv | 219 +++++++++++++++++++++
 tb/tb_spi_slave_bmm150_regs.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_bmm150_regs.sv
// spi_slave_bmm150_regs
//   SPI mode-0 responder that emulates the BMM150 register interface. A command
//   byte {rw, addr[6:0]} (rw=1 read) is followed by one data byte that is either
//   written into the local register file or returned on MISO. A side port lets
//   the sensor model load measurement registers.
//
//   Optional feature macro: SPI_BURST_EN
//     defined   : address auto-increments after each data byte (multi-byte burst)
//     undefined : single data byte per transfer, extra bytes ignored with miso=0
//
// Ports
//   clk, rst              system clock, synchronous active-high reset
//   sclk, cs_n, mosi      asynchronous SPI inputs (CPOL=0, CPHA=0, MSB first)
//   miso, miso_oe         SPI data out and pad output enable (synced cs_n low)
//   load_en/addr/data     side-port register load; wins over a same-address SPI write
//   wr_valid/addr/data    one-cycle commit pulse, address/data held until next commit
module spi_slave_bmm150_regs #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [6:0]  BASE_ADDR   = 7'h40,
  parameter int unsigned NUM_REGS    = 50,
  parameter logic [7:0]  CHIP_ID     = 8'h32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  input  logic       load_en,
  input  logic [6:0] load_addr,
  input  logic [7:0] load_data,
  output logic       wr_valid,
  output logic [6:0] wr_addr,
  output logic [7:0] wr_data
);

  localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMD  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Address decode helpers
  function automatic logic is_mapped(input logic [6:0] a);
    logic [7:0] off;
    off = {1'b0, a} - {1'b0, BASE_ADDR};
    return ({1'b0, a} >= {1'b0, BASE_ADDR}) && (off < 8'(NUM_REGS));
  endfunction

  function automatic logic [IDX_W-1:0] reg_idx(input logic [6:0] a);
    logic [7:0] off;
    off = {1'b0, a} - {1'b0, BASE_ADDR};
    return IDX_W'(off);
  endfunction

  // Input synchronizers plus one history flop for edge detection. Left out of
  // reset so a cs_n held low across rst cannot fake a falling edge afterwards.
  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_hist, cs_hist;

  always_ff @(posedge clk) begin
    sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
    cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
    mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
    sclk_hist <= sclk_sync[SYNC_STAGES-1];
    cs_hist   <= cs_sync[SYNC_STAGES-1];
  end

  logic sclk_lvl, cs_lvl, mosi_lvl;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;

  assign sclk_lvl  = sclk_sync[SYNC_STAGES-1];
  assign cs_lvl    = cs_sync[SYNC_STAGES-1];
  assign mosi_lvl  = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_lvl & ~sclk_hist;
  assign sclk_fall = ~sclk_lvl & sclk_hist;
  assign cs_rise   = cs_lvl & ~cs_hist;
  assign cs_fall   = ~cs_lvl & cs_hist;

  // Transfer state
  logic [1:0] state, state_nxt;
  logic [2:0] bit_cnt;
  logic [6:0] rx_shift;
  logic [7:0] tx_shift;
  logic       rw_q;
  logic [6:0] addr_q;
  logic [7:0] regs [NUM_REGS];

  logic [7:0] rx_byte;
  logic       byte_done;
  logic [6:0] fetch_addr;
  logic       fetch_rw;
  logic [7:0] fetch_byte;
  logic       spi_commit;
  logic       load_ok;

  assign rx_byte   = {rx_shift, mosi_lvl};
  assign byte_done = sclk_rise && (bit_cnt == 3'd7);

  // Read fetch: command byte in CMD, next sequential address in DATA (burst)
  always_comb begin
    fetch_addr = addr_q + 7'd1;
    fetch_rw   = rw_q;
    if (state == ST_CMD) begin
      fetch_addr = rx_byte[6:0];
      fetch_rw   = rx_byte[7];
    end
    fetch_byte = 8'h00;
    if (fetch_rw && is_mapped(fetch_addr)) fetch_byte = regs[reg_idx(fetch_addr)];
  end

  // Write qualification: mapped and not the read-only chip-id location
  assign spi_commit = (state == ST_DATA) && byte_done && !cs_rise && !rw_q &&
                      is_mapped(addr_q) && (addr_q != BASE_ADDR);
  assign load_ok    = load_en && is_mapped(load_addr) && (load_addr != BASE_ADDR);

  // Register file; the side-port load is applied last so it wins a collision
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[IDX_W'(i)] <= (i == 0) ? CHIP_ID : 8'h00;
      end
    end else begin
      if (spi_commit) regs[reg_idx(addr_q)]    <= rx_byte;
      if (load_ok)    regs[reg_idx(load_addr)] <= load_data;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (cs_fall) state_nxt = ST_CMD;
      ST_CMD:  if (byte_done) state_nxt = ST_DATA;
      ST_DATA: begin
`ifdef SPI_BURST_EN
        state_nxt = ST_DATA;
`else
        if (byte_done) state_nxt = ST_DONE;
`endif
      end
      ST_DONE: state_nxt = ST_DONE;
    endcase
    if (cs_rise) state_nxt = ST_IDLE;
  end

  // Shift datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt  <= 3'd0;
      rx_shift <= 7'd0;
      tx_shift <= 8'd0;
      rw_q     <= 1'b0;
      addr_q   <= 7'd0;
      miso     <= 1'b0;
      miso_oe  <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr  <= 7'd0;
      wr_data  <= 8'd0;
    end else begin
      wr_valid <= 1'b0;
      miso_oe  <= ~cs_lvl;
      if (cs_rise) begin
        // abort: any partial byte is simply abandoned
        bit_cnt <= 3'd0;
        miso    <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            miso    <= 1'b0;
            bit_cnt <= 3'd0;
          end
          ST_CMD: begin
            if (sclk_rise) begin
              rx_shift <= rx_byte[6:0];
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                rw_q     <= rx_byte[7];
                addr_q   <= rx_byte[6:0];
                tx_shift <= fetch_byte;  // snapshot; later loads do not disturb it
              end
            end
          end
          ST_DATA: begin
            if (sclk_fall) begin
              miso     <= tx_shift[7];
              tx_shift <= {tx_shift[6:0], 1'b0};
            end
            if (sclk_rise) begin
              rx_shift <= rx_byte[6:0];
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (spi_commit) begin
                  wr_valid <= 1'b1;
                  wr_addr  <= addr_q;
                  wr_data  <= rx_byte;
                end
`ifdef SPI_BURST_EN
                addr_q   <= addr_q + 7'd1;
                tx_shift <= fetch_byte;
`endif
              end
            end
          end
          default: miso <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_bmm150_regs.sv
// tb_spi_slave_bmm150_regs
//   Directed bench: a bit-level SPI master drives transfers, expected read bytes
//   and expected write commits are queued, and two monitors (SPI bus, commit
//   port) pop and compare independently of the stimulus.
module tb_spi_slave_bmm150_regs;

  localparam int unsigned HALF = 4;  // SCLK half period in clk cycles

  logic       clk       = 1'b0;
  logic       rst       = 1'b1;
  logic       sclk      = 1'b0;
  logic       cs_n      = 1'b1;
  logic       mosi      = 1'b0;
  logic       load_en   = 1'b0;
  logic [6:0] load_addr = 7'd0;
  logic [7:0] load_data = 8'd0;
  logic       miso, miso_oe, wr_valid;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  exp_rd [$];
  logic [14:0] exp_wr [$];

  spi_slave_bmm150_regs dut (
    .clk       (clk),
    .rst       (rst),
    .sclk      (sclk),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .miso      (miso),
    .miso_oe   (miso_oe),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .wr_valid  (wr_valid),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // SPI bus monitor: first 8 rises carry the command, then every 8 rises a data byte
  int         mon_cnt = 0;
  logic [7:0] mon_cmd = 8'd0;
  logic [7:0] mon_byte = 8'd0;

  always @(posedge sclk or negedge cs_n) begin
    if (!sclk) begin
      mon_cnt = 0;
    end else if (!cs_n) begin
      mon_cnt++;
      if (mon_cnt <= 8) mon_cmd  = {mon_cmd[6:0], mosi};
      else              mon_byte = {mon_byte[6:0], miso};
      if (mon_cnt > 8 && (mon_cnt % 8) == 0 && mon_cmd[7]) begin
        if (exp_rd.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL rd_unexpected: got byte 0x%0h with no expected read queued", mon_byte);
        end else begin
          check("rd_byte", {8'h00, mon_byte}, {8'h00, exp_rd.pop_front()});
        end
      end
    end
  end

  // Commit monitor
  always @(negedge clk) begin
    if (!rst && wr_valid) begin
      if (exp_wr.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL wr_unexpected: got addr 0x%0h data 0x%0h, expected no commit", wr_addr, wr_data);
      end else begin
        check("wr_commit", {1'b0, wr_addr, wr_data}, {1'b0, exp_wr.pop_front()});
      end
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_bit(input logic b);
    mosi = b;
    wait_clks(HALF);
    sclk = 1'b1;
    wait_clks(HALF);
    sclk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) spi_bit(b[i]);
  endtask

  task automatic cs_begin();
    cs_n = 1'b0;
    wait_clks(HALF);
  endtask

  task automatic cs_end();
    wait_clks(HALF);
    cs_n = 1'b1;
    wait_clks(2 * HALF);
  endtask

  task automatic spi_read(input logic [6:0] a, input int nbytes);
    cs_begin();
    spi_byte({1'b1, a});
    for (int i = 0; i < nbytes; i++) spi_byte(8'h00);
    cs_end();
  endtask

  task automatic spi_write(input logic [6:0] a, input logic [7:0] d);
    cs_begin();
    spi_byte({1'b0, a});
    spi_byte(d);
    cs_end();
  endtask

  task automatic load(input logic [6:0] a, input logic [7:0] d);
    load_addr = a;
    load_data = d;
    load_en   = 1'b1;
    wait_clks(1);
    load_en   = 1'b0;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [7:0] part_data;
    logic [7:0] coll_data;
    logic [7:0] rst_data;
    part_data = 8'h55;
    coll_data = 8'h22;
    rst_data  = 8'hC3;

    wait_clks(6);
    rst = 1'b0;
    wait_clks(2);
    check("rst_miso",     {15'd0, miso},     16'd0);
    check("rst_miso_oe",  {15'd0, miso_oe},  16'd0);
    check("rst_wr_valid", {15'd0, wr_valid}, 16'd0);
    check("rst_wr_addr",  {9'd0, wr_addr},   16'd0);
    check("rst_wr_data",  {8'd0, wr_data},   16'd0);

    // chip id read
    exp_rd.push_back(8'h32);
    spi_read(7'h40, 1);

    // plain write then readback
    exp_wr.push_back({7'h4B, 8'h01});
    spi_write(7'h4B, 8'h01);
    exp_rd.push_back(8'h01);
    spi_read(7'h4B, 1);
    check("wr_addr_hold", {9'd0, wr_addr}, 16'h004B);
    check("wr_data_hold", {8'd0, wr_data}, 16'h0001);

    // side-port load visible to SPI
    load(7'h42, 8'hA5);
    exp_rd.push_back(8'hA5);
    spi_read(7'h42, 1);

    // chip id is read-only for SPI and side port
    spi_write(7'h40, 8'hFF);
    exp_rd.push_back(8'h32);
    spi_read(7'h40, 1);
    load(7'h40, 8'h00);
    exp_rd.push_back(8'h32);
    spi_read(7'h40, 1);

    // aborted write after 5 data bits
    cs_begin();
    spi_byte(8'h4C);
    for (int i = 7; i >= 3; i--) spi_bit(part_data[i]);
    cs_end();
    exp_rd.push_back(8'h00);
    spi_read(7'h4C, 1);

    // same-cycle side-port load and SPI commit to 0x4D: load data stays, wr_data shows SPI data.
    // load_en spans the three clk edges after the last rising SCLK, ending on the commit edge.
    exp_wr.push_back({7'h4D, 8'h22});
    cs_begin();
    spi_byte(8'h4D);
    for (int i = 7; i >= 1; i--) spi_bit(coll_data[i]);
    mosi = coll_data[0];
    wait_clks(HALF);
    sclk      = 1'b1;
    load_addr = 7'h4D;
    load_data = 8'h11;
    load_en   = 1'b1;
    wait_clks(3);
    load_en   = 1'b0;
    wait_clks(HALF - 3);
    sclk      = 1'b0;
    cs_end();
    exp_rd.push_back(8'h11);
    spi_read(7'h4D, 1);

    // unmapped addresses and the last mapped one
    spi_write(7'h72, 8'h99);
    exp_rd.push_back(8'h00);
    spi_read(7'h72, 1);
    exp_rd.push_back(8'h00);
    spi_read(7'h3F, 1);
    exp_wr.push_back({7'h71, 8'h5A});
    spi_write(7'h71, 8'h5A);
    exp_rd.push_back(8'h5A);
    spi_read(7'h71, 1);

    // read byte snapshotted at the command: a load during the data phase is not seen
    load(7'h43, 8'h77);
    exp_rd.push_back(8'h77);
    cs_begin();
    spi_byte(8'hC3);
    load(7'h43, 8'h88);
    spi_byte(8'h00);
    cs_end();
    exp_rd.push_back(8'h88);
    spi_read(7'h43, 1);

    // pad enable follows chip select
    cs_n = 1'b0;
    wait_clks(HALF + 2);
    check("miso_oe_active", {15'd0, miso_oe}, 16'd1);
    cs_n = 1'b1;
    wait_clks(HALF + 2);
    check("miso_oe_idle", {15'd0, miso_oe}, 16'd0);

    // eight-byte read from 0x42
    for (int i = 0; i < 8; i++) load(7'h42 + 7'(i), 8'(i + 1));
`ifdef SPI_BURST_EN
    for (int i = 0; i < 8; i++) exp_rd.push_back(8'(i + 1));
`else
    exp_rd.push_back(8'h01);
    for (int i = 1; i < 8; i++) exp_rd.push_back(8'h00);
`endif
    spi_read(7'h42, 8);

    // reset mid-transfer: the rest of that transfer is ignored, registers clear
    cs_begin();
    spi_byte(8'h4E);
    for (int i = 7; i >= 4; i--) spi_bit(rst_data[i]);
    rst = 1'b1;
    wait_clks(2);
    check("midrst_miso_oe", {15'd0, miso_oe}, 16'd0);
    check("midrst_miso",    {15'd0, miso},    16'd0);
    rst = 1'b0;
    for (int i = 3; i >= 0; i--) spi_bit(rst_data[i]);
    cs_end();
    check("midrst_wr_addr", {9'd0, wr_addr}, 16'd0);
    check("midrst_wr_data", {8'd0, wr_data}, 16'd0);
    exp_rd.push_back(8'h00);
    spi_read(7'h4B, 1);
    exp_rd.push_back(8'h32);
    spi_read(7'h40, 1);

    wait_clks(20);
    check("rd_queue_drained", 16'(exp_rd.size()), 16'd0);
    check("wr_queue_drained", 16'(exp_wr.size()), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
